// File: rtl/perf_stats_unit.sv
`default_nettype none
// ============================================================================
// perf_stats_unit: saturating retire/cache event counters that freeze on halt,
// read back through a registered select port. Miss counters: PERF_STATS_MISS_EN.
// Revision: 1.0
// ============================================================================
module perf_stats_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             clr,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted,
  output logic [7:0]       ovf,
  output logic             proto_err
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam int              c_num_cnt = 8;
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
`ifdef PERF_STATS_MISS_EN
  localparam logic [7:0]      c_cnt_impl = 8'hFF;
`else
  localparam logic [7:0]      c_cnt_impl = 8'h3F;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [c_num_cnt];
  logic [CNT_W-1:0]   cnt_d [c_num_cnt];
  logic [7:0]         ovf_q, ovf_d;
  logic               proto_err_q, proto_err_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic [7:0]         ev;
  logic               orphan_hit;

  always_comb begin
    state_d     = state_q;
    ovf_d       = ovf_q;
    proto_err_d = proto_err_q;
    // Read port captures the pre-update value of the selected counter.
    rd_data_d   = cnt_q[rd_sel];
    for (int i = 0; i < c_num_cnt; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    ev    = 8'h00;
    ev[0] = 1'b1;
    ev[1] = retire | halt;
    ev[2] = icache_req;
    ev[3] = icache_req & icache_hit;
    ev[4] = dcache_req;
    ev[5] = dcache_req & dcache_hit;
    ev[6] = icache_req & ~icache_hit;
    ev[7] = dcache_req & ~dcache_hit;
    ev    = ev & c_cnt_impl;

    orphan_hit = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);

    if (clr) begin
      state_d     = RUN;
      ovf_d       = 8'h00;
      proto_err_d = 1'b0;
      for (int i = 0; i < c_num_cnt; i++) begin
        cnt_d[i] = '0;
      end
    end else if (state_q == RUN) begin
      for (int i = 0; i < c_num_cnt; i++) begin
        if (ev[i]) begin
          if (&cnt_q[i]) begin
            ovf_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + c_one;
          end
        end
      end
      if (orphan_hit) begin
        proto_err_d = 1'b1;
      end
      if (halt) begin
        state_d = HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ovf_q       <= 8'h00;
      proto_err_q <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < c_num_cnt; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ovf_q       <= ovf_d;
      proto_err_q <= proto_err_d;
      rd_data_q   <= rd_data_d;
      for (int i = 0; i < c_num_cnt; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign halted    = (state_q == HALTED);
  assign ovf       = ovf_q;
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_stats_unit.sv
`default_nettype none
// tb_perf_stats_unit: table-driven vectors plus a per-cycle scoreboard for
// perf_stats_unit, built with an 8-bit counter width to reach saturation.
module tb_perf_stats_unit;
  localparam int W = 8;
`ifdef PERF_STATS_MISS_EN
  localparam bit MISS_ON = 1'b1;
`else
  localparam bit MISS_ON = 1'b0;
`endif

  localparam logic [6:0] RET = 7'b1000000;
  localparam logic [6:0] HLT = 7'b0100000;
  localparam logic [6:0] ICR = 7'b0010000;
  localparam logic [6:0] ICH = 7'b0001000;
  localparam logic [6:0] DCR = 7'b0000100;
  localparam logic [6:0] DCH = 7'b0000010;
  localparam logic [6:0] CLR = 7'b0000001;

  logic         clk = 1'b0;
  logic         rst, retire, halt, icache_req, icache_hit, dcache_req, dcache_hit, clr;
  logic [2:0]   rd_sel;
  logic [W-1:0] rd_data;
  logic         halted;
  logic [7:0]   ovf;
  logic         proto_err;

  perf_stats_unit #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .retire     (retire),
    .halt       (halt),
    .icache_req (icache_req),
    .icache_hit (icache_hit),
    .dcache_req (dcache_req),
    .dcache_hit (dcache_hit),
    .clr        (clr),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .halted     (halted),
    .ovf        (ovf),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [6:0] ctl;
    logic [2:0] sel;
    logic       chk;
    logic [W-1:0] exp_rd;
    logic       exp_halted;
    logic [7:0] exp_ovf;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic [W-1:0] rd;
    logic         halted;
    logic [7:0]   ovf;
    logic         perr;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference state
  logic [W-1:0] m_cnt [8];
  logic [7:0]   m_ovf;
  logic         m_perr;
  logic         m_halted;

  function automatic vec_t mk(int n, logic [6:0] ctl, logic [2:0] sel, logic chk = 1'b0,
                              logic [W-1:0] rd = '0, logic h = 1'b0, logic [7:0] o = 8'h00,
                              logic p = 1'b0);
    vec_t v;
    v.n = n; v.ctl = ctl; v.sel = sel; v.chk = chk;
    v.exp_rd = rd; v.exp_halted = h; v.exp_ovf = o; v.exp_perr = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_step(input logic r, input vec_t v, output exp_t e);
    logic [7:0] inc;
    logic ret_i, hlt_i, icr_i, ich_i, dcr_i, dch_i, clr_i;
    {ret_i, hlt_i, icr_i, ich_i, dcr_i, dch_i, clr_i} = v.ctl;
    e.rd = r ? '0 : m_cnt[v.sel];
    if (r || clr_i) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = '0;
      m_ovf = 8'h00; m_perr = 1'b0; m_halted = 1'b0;
    end else if (!m_halted) begin
      inc = {MISS_ON && dcr_i && !dch_i, MISS_ON && icr_i && !ich_i,
             dcr_i && dch_i, dcr_i, icr_i && ich_i, icr_i, ret_i || hlt_i, 1'b1};
      for (int i = 0; i < 8; i++) begin
        if (inc[i]) begin
          if (m_cnt[i] == {W{1'b1}}) m_ovf[i] = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1'b1;
        end
      end
      if ((ich_i && !icr_i) || (dch_i && !dcr_i)) m_perr = 1'b1;
      if (hlt_i) m_halted = 1'b1;
    end
    e.halted = m_halted; e.ovf = m_ovf; e.perr = m_perr;
  endtask

  task automatic apply(input logic r, input vec_t v, output exp_t got);
    exp_t e;
    exp_t x;
    rst = r;
    {retire, halt, icache_req, icache_hit, dcache_req, dcache_hit, clr} = v.ctl;
    rd_sel = v.sel;
    model_step(r, v, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got.rd = rd_data; got.halted = halted; got.ovf = ovf; got.perr = proto_err;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check("sb_rd",     32'(rd_data),   32'(x.rd));
      check("sb_halted", 32'(halted),    32'(x.halted));
      check("sb_ovf",    32'(ovf),       32'(x.ovf));
      check("sb_perr",   32'(proto_err), 32'(x.perr));
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t g;
    for (int k = 0; k < v.n; k++) begin
      apply(1'b0, v, g);
    end
    if (v.chk) begin
      check($sformatf("vec%0d_rd", idx),     32'(g.rd),     32'(v.exp_rd));
      check($sformatf("vec%0d_halted", idx), 32'(g.halted), 32'(v.exp_halted));
      check($sformatf("vec%0d_ovf", idx),    32'(g.ovf),    32'(v.exp_ovf));
      check($sformatf("vec%0d_perr", idx),   32'(g.perr),   32'(v.exp_perr));
    end
  endtask

  initial begin
    exp_t g;
    vec_t rv;
    logic [6:0] c;

    rst = 1'b1; retire = 0; halt = 0; icache_req = 0; icache_hit = 0;
    dcache_req = 0; dcache_hit = 0; clr = 0; rd_sel = 3'd0;
    for (int i = 0; i < 8; i++) m_cnt[i] = '0;
    m_ovf = 8'h00; m_perr = 1'b0; m_halted = 1'b0;

    apply(1'b1, mk(1, 7'd0, 3'd0), g);
    apply(1'b1, mk(1, RET | ICR | HLT, 3'd1), g);
    check("reset_rd",     32'(g.rd),     32'd0);
    check("reset_halted", 32'(g.halted), 32'd0);
    check("reset_ovf",    32'(g.ovf),    32'd0);
    check("reset_perr",   32'(g.perr),   32'd0);

    // Idle counting and zero reads of every other select
    vecs.push_back(mk(10, 7'd0, 3'd0));
    vecs.push_back(mk(1, 7'd0, 3'd0, 1'b1, 8'd10));
    for (int s = 1; s < 8; s++) vecs.push_back(mk(1, 7'd0, 3'(s), 1'b1, 8'd0));
    // I-cache: 8 requests, 3 hits
    vecs.push_back(mk(3, ICR | ICH, 3'd0));
    vecs.push_back(mk(5, ICR, 3'd0));
    vecs.push_back(mk(1, 7'd0, 3'd2, 1'b1, 8'd8));
    vecs.push_back(mk(1, 7'd0, 3'd3, 1'b1, 8'd3));
    vecs.push_back(mk(1, 7'd0, 3'd6, 1'b1, MISS_ON ? 8'd5 : 8'd0));
    // Orphan D-cache hit, then legitimate D-cache traffic
    vecs.push_back(mk(1, DCH, 3'd5, 1'b1, 8'd0, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(1, 7'd0, 3'd5, 1'b1, 8'd0, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(2, DCR | DCH, 3'd0));
    vecs.push_back(mk(1, DCR, 3'd0));
    vecs.push_back(mk(1, 7'd0, 3'd4, 1'b1, 8'd3, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(1, 7'd0, 3'd5, 1'b1, 8'd2, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(1, 7'd0, 3'd7, 1'b1, MISS_ON ? 8'd1 : 8'd0, 1'b0, 8'h00, 1'b1));
    // Clear: read shows pre-clear cycles, then zeros
    vecs.push_back(mk(1, CLR, 3'd0, 1'b1, 8'd37));
    vecs.push_back(mk(1, 7'd0, 3'd0, 1'b1, 8'd0));
    vecs.push_back(mk(1, 7'd0, 3'd4, 1'b1, 8'd0));
    // Halt with retire counts once, then freeze under toggling strobes
    vecs.push_back(mk(5, RET, 3'd0));
    vecs.push_back(mk(1, RET | HLT, 3'd1, 1'b1, 8'd5, 1'b1));
    vecs.push_back(mk(5, RET | ICR | ICH, 3'd0));
    vecs.push_back(mk(5, HLT | DCH, 3'd0));
    vecs.push_back(mk(5, DCR | ICH, 3'd0));
    vecs.push_back(mk(5, RET | ICR, 3'd0));
    vecs.push_back(mk(1, 7'd0, 3'd1, 1'b1, 8'd6, 1'b1));
    vecs.push_back(mk(1, 7'd0, 3'd0, 1'b1, 8'd8, 1'b1));
    vecs.push_back(mk(1, 7'd0, 3'd2, 1'b1, 8'd0, 1'b1));
    // Clear leaves HALTED; clear with halt discards the halt
    vecs.push_back(mk(1, CLR, 3'd0, 1'b1, 8'd8));
    vecs.push_back(mk(1, CLR | HLT | RET, 3'd1, 1'b1, 8'd0));
    vecs.push_back(mk(1, 7'd0, 3'd1, 1'b1, 8'd0));
    vecs.push_back(mk(1, 7'd0, 3'd0, 1'b1, 8'd1));
    // Saturation, then clear and resume
    vecs.push_back(mk(300, RET, 3'd1));
    vecs.push_back(mk(1, 7'd0, 3'd1, 1'b1, 8'd255, 1'b0, 8'h03));
    vecs.push_back(mk(1, 7'd0, 3'd0, 1'b1, 8'd255, 1'b0, 8'h03));
    vecs.push_back(mk(1, CLR, 3'd0, 1'b1, 8'd255));
    vecs.push_back(mk(1, 7'd0, 3'd1, 1'b1, 8'd0));
    vecs.push_back(mk(3, RET, 3'd0));
    vecs.push_back(mk(1, 7'd0, 3'd1, 1'b1, 8'd3));

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Orphan hit in a clearing cycle leaves no error; alone it sets one
    apply(1'b0, mk(1, ICH | CLR, 3'd3), g);
    check("clr_orphan_perr", 32'(g.perr), 32'd0);
    apply(1'b0, mk(1, ICH, 3'd3), g);
    check("orphan_perr", 32'(g.perr), 32'd1);
    apply(1'b0, mk(1, 7'd0, 3'd3), g);
    check("orphan_not_counted", 32'(g.rd), 32'd0);

    // Reset while HALTED
    apply(1'b0, mk(1, HLT, 3'd0), g);
    check("halt_rises", 32'(g.halted), 32'd1);
    apply(1'b1, mk(1, RET | ICR, 3'd3), g);
    check("rst_halted_rd",     32'(g.rd),     32'd0);
    check("rst_halted_halted", 32'(g.halted), 32'd0);
    check("rst_halted_perr",   32'(g.perr),   32'd0);
    apply(1'b0, mk(1, 7'd0, 3'd0), g);
    check("post_rst_cycles", 32'(g.rd), 32'd0);
    apply(1'b0, mk(1, 7'd0, 3'd0), g);
    check("post_rst_count", 32'(g.rd), 32'd1);

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      c = 7'($urandom_range(0, 127)) & ~(HLT | CLR);
      if ($urandom_range(0, 15) == 0) c = c | HLT;
      if ($urandom_range(0, 11) == 0) c = c | CLR;
      rv = mk(1, c, 3'($urandom_range(0, 7)));
      apply(1'b0, rv, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/perf_stats_unit.md
# perf_stats_unit

Synthesizable performance-statistics block downstream of the processor's retire and cache-interface signals. Each cycle it samples instruction-retire, halt and I/D cache request/hit strobes and accumulates saturating event counters. It freezes on halt, so the final statistics stay readable on silicon. It mirrors the cycle, instruction and cache counts the simulation bench reports, as hardware counters read through a registered select port.

## Interface
- `CNT_W`, default 32: counter width in bits, legal range 8–32.
- `clk`  in  1: processor clock.
- `rst`  in  1: synchronous, active-high reset.
- `retire`  in  1: an instruction retired this cycle (RegWrite | MemWrite at writeback).
- `halt`  in  1: halt instruction retired this cycle.
- `icache_req`  in  1: valid instruction-cache request.
- `icache_hit`  in  1: instruction-cache hit, qualified by `icache_req`.
- `dcache_req`  in  1: valid data-cache read or write request.
- `dcache_hit`  in  1: data-cache hit, qualified by `dcache_req`.
- `clr`  in  1: synchronous clear of counters and flags; resumes counting.
- `rd_sel`  in  3: counter select.
- `rd_data`  out  CNT_W: registered counter value.
- `halted`  out  1: unit is frozen after halt.
- `ovf`  out  8: sticky saturation flag per counter, indexed by `rd_sel` encoding.
- `proto_err`  out  1: sticky flag; a hit was seen without its request.

## Operation
- Counter map by `rd_sel`:
  - 0 cycles.
  - 1 instructions.
  - 2 icache_req.
  - 3 icache_hit.
  - 4 dcache_req.
  - 5 dcache_hit.
  - 6 icache_miss.
  - 7 dcache_miss.
- FSM states:
  - RUN (reset state).
  - HALTED.
- Transitions:
  - RUN → HALTED on an edge with `halt`=1 and `clr`=0.
  - HALTED → RUN only on `clr`=1 or `rst`=1.
- In RUN, at each edge:
  - cycles +1.
  - instructions +1 if `retire` | `halt`; a halt counts as one instruction, and `retire` with `halt` together still counts one.
  - icache_req +1 if `icache_req`.
  - icache_hit +1 if `icache_req & icache_hit`.
  - icache_miss +1 if `icache_req & ~icache_hit`.
  - D-side counters (4, 5, 7) use the same rules with the `dcache_*` inputs.
- Halt cycle: the edge that samples `halt` still applies all increments for that cycle, then the unit freezes.
- In HALTED: no counter, `ovf` or `proto_err` change; inputs are ignored.
- Saturation: a counter at all-ones stays at all-ones and sets its `ovf` bit. `ovf` bits never clear except on `rst`/`clr`.
- `proto_err` is set in RUN when `icache_hit & ~icache_req` or `dcache_hit & ~dcache_req`. The orphan hit is not counted.
- `clr` has priority over every event in the same cycle: all counters, `ovf` and `proto_err` go to 0, state goes to RUN, and a simultaneous `halt` is discarded.
- `rst` has priority over `clr`. Reset mid-run discards all accumulated counts.

## Timing
- Reset values:
  - `rd_data`=0.
  - `halted`=0.
  - `ovf`=0.
  - `proto_err`=0.
  - All counters 0.
  - State RUN.
- All updates occur on the rising edge of `clk`. There are no combinational input→output paths.
- Read latency is 1 cycle: after edge N, `rd_data` holds counter[`rd_sel` sampled at N] as it was **before** edge N's increments.
- `halted` rises the edge after the cycle `halt` is sampled, together with the final increments.
- `ovf`/`proto_err` assert on the same edge as the saturating or erroneous event.
- Throughput: one event set per cycle with no back-pressure; all strobes are single-cycle pulses sampled every edge.

## Configuration
- Macro: `PERF_STATS_MISS_EN`.
- Defined: miss counters 6 and 7 are implemented as described, with `ovf[7:6]` live.
- Undefined: counters 6 and 7 are not built, selects 6 and 7 read 0, and `ovf[7:6]` are tied 0. All other behaviour is identical.

## Test plan
- Reset, 10 idle cycles, read sel 0 → `rd_data`=10 on the read cycle; every other select reads 0; `halted`=0.
- 5 cycles of `retire`=1, then `halt`=1 for one cycle with `retire`=1 → instructions=6, `halted`=1. After 20 more cycles with strobes toggling, cycles and instructions are unchanged.
- 8 `icache_req` pulses with `icache_hit` on 3 of them → sel 2=8, sel 3=3, sel 6=5 (macro on) or sel 6=0 (macro off).
- `dcache_hit`=1 with `dcache_req`=0 → `proto_err`=1; sel 5 unchanged; flag persists until `clr`.
- `CNT_W`=8, `retire` held 300 cycles → sel 1 reads 255, `ovf[1]`=1, `ovf[0]`=1. Then `clr` → all counters and flags 0, counting resumes.
- `clr` and `halt` in the same cycle while in RUN → `halted` stays 0 and all counters read 0 the next cycle. `rst` asserted in HALTED → back to RUN with all outputs 0.
